marker_holdover: RTL

- Sits directly downstream of the marker watchdog. It consumes the raw 1 PPS marker and the watchdog's qualification bit, `markerValid`.
- Produces a clean, fixed-width, sysClk-aligned 1 PPS output (`markerOut`). `markerOut` phase-locks to qualified external markers and free-runs (holdover) when qualification is lost.
- Reports lock state and per-second phase error for status registers.

---
 rtl/marker_pkg.sv | 15 +
 rtl/marker_edge_sync.sv | 37 +++
 rtl/marker_holdover.sv | 130 +++++++++++++
 3 files changed

// File: rtl/marker_pkg.sv
// marker_pkg: shared lock-state encoding and width helper for 1 PPS marker consumers
package marker_pkg;

  typedef enum logic [1:0] {
    FREERUN  = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } marker_state_e;

  function automatic int cnt_width(input int freq);
    return (freq > 1) ? $clog2(freq) : 1;
  endfunction

endpackage

// File: rtl/marker_edge_sync.sv
// marker_edge_sync: synchronizes a raw marker, detects its rising edge and registers it as evalPulse
module marker_edge_sync (
  input  logic sysClk,
  input  logic sysReset_n,
  input  logic markerIn,
  output logic evalPulse
);

  logic s1_q, s2_q, dly_q, eval_q;
  logic s1_d, s2_d, dly_d, eval_d;

  // two-flop synchronizer, delay stage and registered rising-edge detect
  always_comb begin
    s1_d   = markerIn;
    s2_d   = s1_q;
    dly_d  = s2_q;
    eval_d = s2_q & ~dly_q;
  end

  // pipeline registers, cleared while reset is held
  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      dly_q  <= 1'b0;
      eval_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      dly_q  <= dly_d;
      eval_q <= eval_d;
    end
  end

  assign evalPulse = eval_q;

endmodule

// File: rtl/marker_holdover.sv
// marker_holdover: regenerates a fixed-width 1 PPS that locks to qualified markers and free-runs in holdover
module marker_holdover
  import marker_pkg::*;
#(
  parameter int SYSCLK_FREQUENCY = 100000000,
  parameter int PULSE_WIDTH      = 4,
  parameter int ACQUIRE_COUNT    = 3,
  parameter int HOLDOVER_LIMIT   = 10,
  localparam int CW = cnt_width(SYSCLK_FREQUENCY),
  localparam int HW = $clog2(HOLDOVER_LIMIT + 1)
) (
  input  logic                 sysClk,
  input  logic                 sysReset_n,
  input  logic                 markerIn,
  input  logic                 markerValid,
  output logic                 markerOut,
  output logic [1:0]           state,
  output logic signed [CW:0]   phaseError,
  output logic                 phaseErrorStrobe,
  output logic [HW-1:0]        holdoverSeconds
);

  localparam int PW = $clog2(PULSE_WIDTH + 1);
  localparam int AW = $clog2(ACQUIRE_COUNT + 1);
  localparam logic [CW-1:0] C_LAST  = CW'(SYSCLK_FREQUENCY - 1);
  localparam logic [CW-1:0] C_HALF  = CW'(SYSCLK_FREQUENCY / 2);
  localparam logic [PW-1:0] W_FULL  = PW'(PULSE_WIDTH);
  localparam logic [AW-1:0] A_DONE  = AW'(ACQUIRE_COUNT);
  localparam logic [HW-1:0] H_LIMIT = HW'(HOLDOVER_LIMIT);
  localparam marker_state_e ACQ_ENTRY = (ACQUIRE_COUNT <= 1) ? LOCKED : ACQUIRE;

  marker_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acq_q, acq_d, acq_inc;
  logic [HW-1:0] hs_q, hs_d, hs_inc;
  logic [PW-1:0] wc_q, wc_d;
  logic signed [CW:0] pe_q, pe_d;
  logic [CW:0] meas;
  logic fire_q, fire_d, out_q, out_d, stb_q, stb_d;
  logic eval_pulse, acc, early, wrap, fire;

  marker_edge_sync u_sync (
    .sysClk     (sysClk),
    .sysReset_n (sysReset_n),
    .markerIn   (markerIn),
    .evalPulse  (eval_pulse)
  );

  // period counter, reload on accepted edges, phase measurement and pulse stretcher
  always_comb begin
    acc    = eval_pulse & markerValid;
    early  = cnt_q >= C_HALF;
    wrap   = cnt_q == C_LAST;
    fire   = acc ? early : wrap;
    cnt_d  = (acc | wrap) ? '0 : cnt_q + CW'(1);
    meas   = early ? {1'b0, cnt_q} - {1'b0, C_LAST} : {1'b0, cnt_q} + (CW + 1)'(1);
    stb_d  = acc & (state_q == ACQUIRE | state_q == LOCKED);
    pe_d   = stb_d ? meas : pe_q;
    fire_d = fire;
    wc_d   = fire_q ? W_FULL : (wc_q != '0 ? wc_q - PW'(1) : '0);
    out_d  = wc_d != '0;
  end

  // lock-state machine with acquisition and holdover-second tracking
  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    hs_d    = hs_q;
    acq_inc = acq_q + AW'(1);
    hs_inc  = (hs_q == H_LIMIT) ? hs_q : hs_q + HW'(1);
    case (state_q)
      FREERUN: if (acc) begin
        state_d = ACQ_ENTRY;
        acq_d   = AW'(1);
      end
      ACQUIRE: if (!markerValid) begin
        state_d = FREERUN;
        acq_d   = '0;
      end else if (acc) begin
        acq_d   = acq_inc;
        state_d = (acq_inc >= A_DONE) ? LOCKED : ACQUIRE;
      end
      LOCKED: if (!markerValid) begin
        state_d = HOLDOVER;
        hs_d    = '0;
      end
      HOLDOVER: if (acc) begin
        state_d = ACQ_ENTRY;
        acq_d   = AW'(1);
        hs_d    = '0;
      end else if (fire) begin
        hs_d    = hs_inc;
        state_d = (hs_inc == H_LIMIT) ? FREERUN : HOLDOVER;
      end
      default: state_d = FREERUN;
    endcase
  end

  // state registers; reset aborts any pulse in progress
  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      state_q <= FREERUN;
      cnt_q   <= '0;
      acq_q   <= '0;
      hs_q    <= '0;
      wc_q    <= '0;
      pe_q    <= '0;
      fire_q  <= 1'b0;
      out_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acq_q   <= acq_d;
      hs_q    <= hs_d;
      wc_q    <= wc_d;
      pe_q    <= pe_d;
      fire_q  <= fire_d;
      out_q   <= out_d;
      stb_q   <= stb_d;
    end
  end

  assign markerOut        = out_q;
  assign state            = state_q;
  assign phaseError       = pe_q;
  assign phaseErrorStrobe = stb_q;
  assign holdoverSeconds  = hs_q;

endmodule
